// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset vector, bubble encoding,
// opcode field position and the fetch FSM state type.
package mips_pkg;

    // sll $0,$0,0 -- decodes as an R-type write to $zero, so it is harmless.
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0040_0000;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: PC register, +4 adder, next-PC selection and the
// word-alignment check on redirect targets.
module program_counter
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(mips_pkg::RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_en,         // low freezes the PC (fault state)
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  misaligned      // redirect to a non-word address
);

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] pc_next;

    // Adder wraps modulo 2^ADDR_WIDTH with no carry out, as intended.
    assign pc_plus4   = pc_reg + ADDR_WIDTH'(4);
    assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
    assign pc         = pc_reg;

    // Next-PC priority: freeze, misaligned redirect (hold), redirect, stall, advance.
    always_comb begin
        pc_next = pc_reg;
        if (!run_en) begin
            pc_next = pc_reg;
        end else if (misaligned) begin
            pc_next = pc_reg;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end else if (stall) begin
            pc_next = pc_reg;
        end else begin
            pc_next = pc_plus4;
        end
    end

    // PC register with asynchronous reset to the boot vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: RUN/FAULT control, IF/ID pipeline register and
// the count of real instructions handed to decode.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(mips_pkg::RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]           imem_rdata_i,
    output logic [31:0]           if_id_instr_o,
    output logic [ADDR_WIDTH-1:0] if_id_pc4_o,
    output logic                  if_id_valid_o,
    output logic [5:0]            opcode_o,
    output logic                  fault_o,
    output logic [31:0]           fetch_count_o
);

    fetch_state_t          state_reg;
    fetch_state_t          state_next;
    logic                  load_fetch;
    logic                  load_bubble;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  misaligned;

    logic [31:0]           if_id_instr_reg;
    logic [ADDR_WIDTH-1:0] if_id_pc4_reg;
    logic                  if_id_valid_reg;
    logic [31:0]           fetch_count_reg;

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_program_counter (
        .clk           (clk),
        .reset         (reset),
        .run_en        (state_reg == RUN),
        .stall         (stall_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    // Next state and IF/ID load selection; a redirect always beats a stall.
    always_comb begin
        state_next  = state_reg;
        load_fetch  = 1'b0;
        load_bubble = 1'b0;
        case (state_reg)
            RUN: begin
                if (misaligned) begin
                    state_next  = FAULT;
                    load_bubble = 1'b1;
                end else if (branch_taken_i) begin
                    load_bubble = 1'b1;   // squash the wrong-path instruction
                end else if (!stall_i) begin
                    load_fetch  = 1'b1;
                end
            end
            FAULT: begin
                load_bubble = 1'b1;       // sticky until reset
            end
            default: begin
                state_next  = FAULT;
                load_bubble = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // IF/ID register and fetched-instruction counter; both hold on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr_reg <= NOP_INSTR;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
            fetch_count_reg <= '0;
        end else if (load_bubble) begin
            if_id_instr_reg <= NOP_INSTR;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
        end else if (load_fetch) begin
            if_id_instr_reg <= imem_rdata_i;
            if_id_pc4_reg   <= pc_plus4;
            if_id_valid_reg <= 1'b1;
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    assign imem_addr_o   = pc;
    assign if_id_instr_o = if_id_instr_reg;
    assign if_id_pc4_o   = if_id_pc4_reg;
    assign if_id_valid_o = if_id_valid_reg;
    assign fault_o       = (state_reg == FAULT);
    assign fetch_count_o = fetch_count_reg;

    // Opcode field routed straight from the IF/ID register to Control.
    genvar gi;
    generate
        for (gi = 0; gi < OPCODE_WIDTH; gi++) begin : g_opcode
            assign opcode_o[gi] = if_id_instr_reg[OPCODE_LSB + gi];
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage with a cycle-level
// behavioural model and randomized stall/redirect traffic.
module tb_instruction_fetch_stage;

    localparam logic [31:0] BOOT_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic [5:0]  opcode_o;
    logic        fault_o;
    logic [31:0] fetch_count_o;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_fault;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_valid_o   (if_id_valid_o),
        .opcode_o        (opcode_o),
        .fault_o         (fault_o),
        .fetch_count_o   (fetch_count_o)
    );

    // ROM[i] = 0x2008_0000 + i, word i counted from the boot vector
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h2008_0000 + ((a - BOOT_PC) >> 2);
    endfunction

    assign imem_rdata_i = rom_word(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = BOOT_PC; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        m_count = '0; m_fault = 1'b0;
    endtask

    // One clock of the architectural rules, applied to the sampled inputs.
    task automatic model_step();
        if (m_fault) begin
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (branch_taken_i && branch_target_i[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (branch_taken_i) begin
            m_pc = branch_target_i;
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (!stall_i) begin
            m_instr = rom_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".addr"},   imem_addr_o,             m_pc);
        check({where, ".instr"},  if_id_instr_o,           m_instr);
        check({where, ".pc4"},    if_id_pc4_o,             m_pc4);
        check({where, ".valid"},  32'(if_id_valid_o),      32'(m_valid));
        check({where, ".opcode"}, 32'(opcode_o),           32'(m_instr[31:26]));
        check({where, ".fault"},  32'(fault_o),            32'(m_fault));
        check({where, ".count"},  fetch_count_o,           m_count);
        $display("[%0t] %s st=%0b br=%0b tgt=%h addr=%h instr=%h v=%0b cnt=%0d flt=%0b",
                 $time, where, stall_i, branch_taken_i, branch_target_i,
                 imem_addr_o, if_id_instr_o, if_id_valid_o, fetch_count_o, fault_o);
    endtask

    // Apply current inputs across one rising edge, then compare.
    task automatic tick(input string where, input logic st, input logic br, input logic [31:0] tgt);
        stall_i = st; branch_taken_i = br; branch_target_i = tgt;
        @(posedge clk);
        #1;
        model_step();
        check_all(where);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("first_pc");

        // free fetch with a 3-cycle stall at PC 0x0040_0008
        tick("free", 0, 0, '0);
        tick("free", 0, 0, '0);
        check("stall_pc", imem_addr_o, 32'h0040_0008);
        for (int i = 0; i < 3; i++) tick("stall", 1, 0, '0);
        tick("free", 0, 0, '0);
        tick("free", 0, 0, '0);
        check("count4", fetch_count_o, 32'd4);
        check("opc08", 32'(opcode_o), 32'h08);

        // redirect beats a simultaneous stall
        tick("br_stall", 1, 1, 32'h0040_0100);
        check("br_addr", imem_addr_o, 32'h0040_0100);
        tick("post_br", 0, 0, '0);
        check("tgt_instr", if_id_instr_o, rom_word(32'h0040_0100));

        // randomized aligned traffic
        for (int i = 0; i < 150; i++) begin
            logic st, br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 7) == 0);
            tgt = {16'h0040, 14'($urandom()), 2'b00};
            tick("rand", st, br, tgt);
        end

        // PC wrap at the top of the address space
        tick("to_top", 0, 1, 32'hFFFF_FFFC);
        tick("wrap", 0, 0, '0);
        check("wrap_addr", imem_addr_o, 32'h0000_0000);
        check("wrap_pc4", if_id_pc4_o, 32'h0000_0000);

        // misaligned redirect -> sticky fault
        tick("back", 0, 1, 32'h0040_0000);
        tick("free", 0, 0, '0);
        tick("misalign", 0, 1, 32'h0040_0102);
        check("fault_hi", 32'(fault_o), 32'd1);
        for (int i = 0; i < 10; i++)
            tick("fault", logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), $urandom());

        // async reset mid-cycle during a redirect
        stall_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h0040_0200;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        branch_taken_i = 1'b0;
        #1;
        check("rst_first", imem_addr_o, BOOT_PC);
        tick("after_rst", 0, 0, '0);
        tick("after_rst", 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
